hex_pio_arbiter: RTL and testbench
==================================

Name: hex_pio_arbiter

Overview:
Two-requester arbiter sharing the single Avalon-MM hex-display PIO slave, e.g. CPU bridge on requester 0 and a hardware score/status unit on requester 1. Each request is one latched single-beat read or write, issued to the slave as a one-cycle chipselect strobe. Sits between the requesters and the PIO slave port. Supports the PIO's data (addr 0), bit-set (addr 4) and bit-clear (addr 5) registers transparently.

Parameters:
DATA_W, 32, data width of requester and slave data buses
ADDR_W, 3, slave address width
ARB_MODE, 1, 1 = round-robin; 0 = fixed priority, requester 0 wins

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
r0_req  in  1  requester 0 request, held until r0_ack
r0_write  in  1  1 = write, 0 = read
r0_address  in  ADDR_W  target slave address
r0_writedata  in  DATA_W  write data
r0_ack  out  1  one-cycle completion pulse
r0_readdata  out  DATA_W  read result, valid when r0_ack = 1
r1_req, r1_write, r1_address, r1_writedata, r1_ack, r1_readdata  as r0_*, for requester 1
m_chipselect  out  1  slave chipselect
m_address  out  ADDR_W  slave address
m_write_n  out  1  slave active-low write strobe
m_writedata  out  DATA_W  slave write data
m_readdata  in  DATA_W  slave read data, zero-latency (combinational in address)
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, reset_n = 0): FSM -> IDLE; m_chipselect 0, m_write_n 1, m_address 0, m_writedata 0; r0_ack/r1_ack 0; r0_readdata/r1_readdata 0; busy 0; last_grant = 1 (so requester 0 wins first round-robin tie).
- Reset mid-transaction: transaction dropped, no ack issued, all outputs immediately take reset values.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req high, select winner, latch winner's write/address/writedata into command register and record winner id -> ACCESS. Else stay.
- Winner selection, ARB_MODE = 1: only one req -> that one; both -> the one not equal to last_grant. ARB_MODE = 0: r0 whenever r0_req high.
- ACCESS (exactly 1 cycle): m_chipselect 1, m_address/m_writedata from command register, m_write_n = ~latched write. On read, capture m_readdata into winner's readdata register at end of cycle. -> RESP.
- RESP (1 cycle): winner's ack = 1; last_grant <- winner id; m_chipselect 0, m_write_n 1. -> IDLE.
- Latency: req first sampled high in IDLE at cycle N -> chipselect cycle N+1 -> ack cycle N+2. Back-to-back throughput: one transaction per 3 cycles.
- Requester rules: hold req and command stable until ack. Req still high in the cycle after ack is a new request.
- Command is latched in IDLE. A requester dropping req after selection still gets its transaction and ack.
- Loser's req is ignored until the next IDLE; no starvation in ARB_MODE 1. Max wait is one other transaction, 3 cycles.
- rN_readdata holds its last captured read value until the next read by the same requester. Writes do not change it.
- Never more than one ack high per cycle. m_chipselect never high outside ACCESS.
- m_address/m_writedata hold last values outside ACCESS; they are don't-care when chipselect is 0.

Test Plan:
- Reset, then r0 writes addr 0 = 0x12345678 -> m_chipselect high exactly one cycle with m_write_n = 0; r0_ack 2 cycles after req; slave data = 0x12345678.
- r1 writes addr 4 = 0x000000F0, then addr 5 = 0x00000010, then reads addr 0 -> r1_readdata = 0x123456E8 on the third ack; r0_ack never pulses.
- r0 and r1 request simultaneously and continuously, ARB_MODE = 1 -> grants alternate r0, r1, r0, r1; ack spacing 3 cycles.
- Same as previous with ARB_MODE = 0 -> r0 granted every time; r1 granted only after r0_req drops.
- r0 drops req one cycle after request (in ACCESS) -> write still performed; r0_ack still pulses once.
- reset_n asserted during ACCESS -> chipselect drops immediately; no ack. After release, FSM is IDLE and the next request completes normally.

Source files
------------

// File: rtl/hex_pio_arbiter.sv
// -----------------------------------------------------------------------------
// hex_pio_arbiter
//
// Shares a single Avalon-MM hex-display PIO slave between two requesters
// (typically a CPU bridge on requester 0 and a score/status unit on
// requester 1). Each request is one single-beat read or write, latched when
// it is granted and issued to the slave as a one-cycle chipselect strobe.
// The PIO data (0), bit-set (4) and bit-clear (5) registers are passed
// through unchanged.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   rN_req                    request, held until rN_ack
//   rN_write                  1 = write, 0 = read
//   rN_address, rN_writedata  command for requester N
//   rN_ack                    one-cycle completion pulse
//   rN_readdata               last read result for requester N
//   m_chipselect, m_address,
//   m_write_n, m_writedata    slave command side
//   m_readdata                slave read data (combinational in address)
//   busy                      high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module hex_pio_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 3,
   parameter int ARB_MODE = 1
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic              r0_req,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_address,
   input  logic [DATA_W-1:0] r0_writedata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_readdata,

   input  logic              r1_req,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_address,
   input  logic [DATA_W-1:0] r1_writedata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_readdata,

   output logic              m_chipselect,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_write_n,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata,

   output logic              busy
);

   // state  | meaning
   // IDLE   | no transaction; pick a winner and latch its command
   // ACCESS | chipselect strobe to the slave; capture read data
   // RESP   | ack pulse to the winner; record it as last grant
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]        state_q,      state_d;
   logic              last_grant_q, last_grant_d;
   logic              winner_q,     winner_d;
   logic              cmd_write_q,  cmd_write_d;
   logic [ADDR_W-1:0] cmd_addr_q,   cmd_addr_d;
   logic [DATA_W-1:0] cmd_wdata_q,  cmd_wdata_d;
   logic [DATA_W-1:0] r0_rdata_q,   r0_rdata_d;
   logic [DATA_W-1:0] r1_rdata_q,   r1_rdata_d;

   logic              pick_r1;

   // Winner selection, only meaningful when at least one request is high.
   // Round-robin hands a tie to whoever was not served last; last_grant
   // resets to requester 1 so requester 0 wins the first tie.
   always_comb begin
      pick_r1 = 1'b0;
      if (ARB_MODE != 0) begin
         pick_r1 = r1_req & (~r0_req | ~last_grant_q);
      end else begin
         pick_r1 = ~r0_req;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      winner_d     = winner_q;
      cmd_write_d  = cmd_write_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      r0_rdata_d   = r0_rdata_q;
      r1_rdata_d   = r1_rdata_q;

      case (state_q)
         IDLE: begin
            if (r0_req | r1_req) begin
               winner_d = pick_r1;
               if (pick_r1) begin
                  cmd_write_d = r1_write;
                  cmd_addr_d  = r1_address;
                  cmd_wdata_d = r1_writedata;
               end else begin
                  cmd_write_d = r0_write;
                  cmd_addr_d  = r0_address;
                  cmd_wdata_d = r0_writedata;
               end
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            // The slave is zero-latency, so its data is valid in this cycle.
            if (!cmd_write_q) begin
               if (winner_q) begin
                  r1_rdata_d = m_readdata;
               end else begin
                  r0_rdata_d = m_readdata;
               end
            end
            state_d = RESP;
         end

         RESP: begin
            last_grant_d = winner_q;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         winner_q     <= 1'b0;
         cmd_write_q  <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         r0_rdata_q   <= '0;
         r1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         winner_q     <= winner_d;
         cmd_write_q  <= cmd_write_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         r0_rdata_q   <= r0_rdata_d;
         r1_rdata_q   <= r1_rdata_d;
      end
   end

   // Outputs decode straight from registered state, so an asynchronous
   // reset takes them to their idle values without waiting for a clock.
   // Address/data hold the last command, which only changes on a grant.
   assign m_chipselect = (state_q == ACCESS);
   assign m_write_n    = ~((state_q == ACCESS) & cmd_write_q);
   assign m_address    = cmd_addr_q;
   assign m_writedata  = cmd_wdata_q;

   assign r0_ack       = (state_q == RESP) & ~winner_q;
   assign r1_ack       = (state_q == RESP) &  winner_q;
   assign r0_readdata  = r0_rdata_q;
   assign r1_readdata  = r1_rdata_q;

   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_hex_pio_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for hex_pio_arbiter. Two instances: index 0 is round-robin,
// index 1 is fixed priority. Each drives its own PIO slave model. The
// reference is transaction-level: a grant at the sampling edge puts the
// strobe in the next cycle and the ack one cycle later, and the arbiter is
// free again three cycles after the strobe.
// -----------------------------------------------------------------------------
module tb_hex_pio_arbiter;
   localparam int DW = 32;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          req   [2][2];
   logic          wr    [2][2];
   logic [AW-1:0] addr  [2][2];
   logic [DW-1:0] wd    [2][2];
   logic          ack   [2][2];
   logic [DW-1:0] rd    [2][2];
   logic          m_cs  [2];
   logic [AW-1:0] m_addr[2];
   logic          m_wn  [2];
   logic [DW-1:0] m_wd  [2];
   logic [DW-1:0] m_rd  [2];
   logic          busy  [2];
   logic [DW-1:0] pio   [2] = '{32'd0, 32'd0};

   hex_pio_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ARB_MODE(1)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .r0_req(req[0][0]), .r0_write(wr[0][0]), .r0_address(addr[0][0]),
      .r0_writedata(wd[0][0]), .r0_ack(ack[0][0]), .r0_readdata(rd[0][0]),
      .r1_req(req[0][1]), .r1_write(wr[0][1]), .r1_address(addr[0][1]),
      .r1_writedata(wd[0][1]), .r1_ack(ack[0][1]), .r1_readdata(rd[0][1]),
      .m_chipselect(m_cs[0]), .m_address(m_addr[0]), .m_write_n(m_wn[0]),
      .m_writedata(m_wd[0]), .m_readdata(m_rd[0]), .busy(busy[0]));

   hex_pio_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ARB_MODE(0)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .r0_req(req[1][0]), .r0_write(wr[1][0]), .r0_address(addr[1][0]),
      .r0_writedata(wd[1][0]), .r0_ack(ack[1][0]), .r0_readdata(rd[1][0]),
      .r1_req(req[1][1]), .r1_write(wr[1][1]), .r1_address(addr[1][1]),
      .r1_writedata(wd[1][1]), .r1_ack(ack[1][1]), .r1_readdata(rd[1][1]),
      .m_chipselect(m_cs[1]), .m_address(m_addr[1]), .m_write_n(m_wn[1]),
      .m_writedata(m_wd[1]), .m_readdata(m_rd[1]), .busy(busy[1]));

   // PIO slave models: data register with bit-set / bit-clear aliases.
   assign m_rd[0] = (m_addr[0] == 3'd0) ? pio[0] : '0;
   assign m_rd[1] = (m_addr[1] == 3'd0) ? pio[1] : '0;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (m_cs[d] && !m_wn[d]) begin
            case (m_addr[d])
               3'd0: pio[d] <= m_wd[d];
               3'd4: pio[d] <= pio[d] | m_wd[d];
               3'd5: pio[d] <= pio[d] & ~m_wd[d];
               default: ;
            endcase
         end
      end
   end

   // Reference model state
   int            cyc;
   int            cs_cyc  [2];
   int            ack_cyc [2];
   int            free_at [2];
   int            win     [2];
   int            last_g  [2];
   logic          t_wr    [2];
   logic [AW-1:0] t_addr  [2];
   logic [DW-1:0] t_wd    [2];
   logic [DW-1:0] t_rval  [2];
   logic [DW-1:0] exp_pio [2];
   logic [DW-1:0] exp_rd  [2][2];
   bit            outst   [2][2];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic logic [DW-1:0] pio_apply(input logic [DW-1:0] cur,
                                               input logic [AW-1:0] a,
                                               input logic [DW-1:0] v);
      case (a)
         3'd0:    return v;
         3'd4:    return cur | v;
         3'd5:    return cur & ~v;
         default: return cur;
      endcase
   endfunction

   function automatic bit model_ack(input int d, input int r);
      return reset_n && (cyc == ack_cyc[d]) && (win[d] == r);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         cs_cyc[d]  = -10;
         ack_cyc[d] = -10;
         free_at[d] = 0;
         last_g[d]  = 1;
         win[d]     = 0;
         for (int r = 0; r < 2; r++) exp_rd[d][r] = '0;
      end
   endtask

   // Called with the inputs that the coming clock edge will sample.
   task automatic model_decide();
      int w;
      if (!reset_n) return;
      for (int d = 0; d < 2; d++) begin
         if (cyc + 1 >= free_at[d] && (req[d][0] || req[d][1])) begin
            if (req[d][0] && req[d][1])
               w = (d == 0) ? ((last_g[d] == 0) ? 1 : 0) : 0;
            else
               w = req[d][0] ? 0 : 1;
            win[d]     = w;
            last_g[d]  = w;
            cs_cyc[d]  = cyc + 1;
            ack_cyc[d] = cyc + 2;
            free_at[d] = cyc + 4;
            t_wr[d]    = wr[d][w];
            t_addr[d]  = addr[d][w];
            t_wd[d]    = wd[d][w];
            t_rval[d]  = (addr[d][w] == 3'd0) ? exp_pio[d] : '0;
         end
      end
   endtask

   task automatic check_all();
      bit cs_exp;
      for (int d = 0; d < 2; d++) begin
         if (!reset_n) begin
            chk($sformatf("d%0d rst cs", d),   m_cs[d],   1'b0);
            chk($sformatf("d%0d rst wn", d),   m_wn[d],   1'b1);
            chk($sformatf("d%0d rst addr", d), m_addr[d], '0);
            chk($sformatf("d%0d rst wd", d),   m_wd[d],   '0);
            chk($sformatf("d%0d rst busy", d), busy[d],   1'b0);
            for (int r = 0; r < 2; r++) begin
               chk($sformatf("d%0d rst ack%0d", d, r), ack[d][r], 1'b0);
               chk($sformatf("d%0d rst rd%0d", d, r),  rd[d][r],  '0);
            end
         end else begin
            if (cyc == ack_cyc[d]) begin
               if (t_wr[d]) exp_pio[d] = pio_apply(exp_pio[d], t_addr[d], t_wd[d]);
               else         exp_rd[d][win[d]] = t_rval[d];
            end
            cs_exp = (cyc == cs_cyc[d]);
            chk($sformatf("d%0d cs", d),   m_cs[d], cs_exp);
            chk($sformatf("d%0d busy", d), busy[d], cs_exp || (cyc == ack_cyc[d]));
            chk($sformatf("d%0d wn", d),   m_wn[d], !(cs_exp && t_wr[d]));
            if (cs_exp) chk($sformatf("d%0d addr", d), m_addr[d], t_addr[d]);
            if (cs_exp && t_wr[d]) chk($sformatf("d%0d wdata", d), m_wd[d], t_wd[d]);
            for (int r = 0; r < 2; r++) begin
               chk($sformatf("d%0d ack%0d", d, r), ack[d][r], model_ack(d, r));
               chk($sformatf("d%0d rd%0d", d, r),  rd[d][r],  exp_rd[d][r]);
            end
            chk($sformatf("d%0d pio", d), pio[d], exp_pio[d]);
         end
      end
   endtask

   task automatic advance();
      model_decide();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_all();
   endtask

   task automatic set_cmd(input int d, input int r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] v);
      req[d][r]  = 1'b1;
      wr[d][r]   = w;
      addr[d][r] = a;
      wd[d][r]   = v;
   endtask

   task automatic do_txn(input int d, input int r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] v,
                         input bit drop_early);
      int start;
      bit got;
      advance();
      advance();
      start = cyc;
      set_cmd(d, r, w, a, v);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         advance();
         if (drop_early && k == 0) req[d][r] = 1'b0;
         if (ack[d][r] === 1'b1) begin
            got = 1'b1;
            chk($sformatf("d%0d r%0d latency", d, r), cyc - start, 2);
            req[d][r] = 1'b0;
         end
      end
      chk($sformatf("d%0d r%0d ack seen", d, r), got, 1'b1);
   endtask

   task automatic new_cmd(input int d, input int r);
      logic [AW-1:0] a;
      case ($urandom_range(0, 3))
         0:       a = 3'd0;
         1:       a = 3'd4;
         2:       a = 3'd5;
         default: a = AW'($urandom_range(0, 7));
      endcase
      outst[d][r] = 1'b1;
      set_cmd(d, r, 1'($urandom_range(0, 1)), a, $urandom);
   endtask

   task automatic rand_stim();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 2; r++) begin
            if (model_ack(d, r)) begin
               outst[d][r] = 1'b0;
               if ($urandom_range(0, 99) < 60) new_cmd(d, r);
               else req[d][r] = 1'b0;
            end else if (!outst[d][r]) begin
               if ($urandom_range(0, 99) < 30) new_cmd(d, r);
            end else if (cyc == cs_cyc[d] && win[d] == r && $urandom_range(0, 99) < 15) begin
               req[d][r] = 1'b0;
            end
         end
      end
   endtask

   initial begin
      int seq[$];
      int when[$];
      int n0;
      int n1;
      bit early_r1;

      for (int d = 0; d < 2; d++) begin
         exp_pio[d] = '0;
         t_wr[d] = 1'b0; t_addr[d] = '0; t_wd[d] = '0; t_rval[d] = '0;
         for (int r = 0; r < 2; r++) begin
            req[d][r] = 1'b0; wr[d][r] = 1'b0; addr[d][r] = '0; wd[d][r] = '0;
            outst[d][r] = 1'b0;
         end
      end
      cyc = 0;
      model_reset();

      // Reset state
      @(negedge clk);
      check_all();
      advance();
      advance();
      reset_n = 1'b1;

      // r0 write to the data register
      do_txn(0, 0, 1'b1, 3'd0, 32'h1234_5678, 1'b0);
      chk("pio after r0 write", pio[0], 32'h1234_5678);

      // r1: bit-set, bit-clear, read back
      do_txn(0, 1, 1'b1, 3'd4, 32'h0000_00F0, 1'b0);
      do_txn(0, 1, 1'b1, 3'd5, 32'h0000_0010, 1'b0);
      do_txn(0, 1, 1'b0, 3'd0, 32'h0, 1'b0);
      chk("r1 readback", rd[0][1], 32'h1234_56E8);

      // Round-robin: both requesting continuously
      advance();
      advance();
      set_cmd(0, 0, 1'b1, 3'd0, 32'hAAAA_0000);
      set_cmd(0, 1, 1'b1, 3'd0, 32'h0000_BBBB);
      for (int k = 0; k < 14; k++) begin
         advance();
         for (int r = 0; r < 2; r++) begin
            if (ack[0][r] === 1'b1) begin
               seq.push_back(r);
               when.push_back(cyc);
            end
         end
      end
      req[0][0] = 1'b0;
      req[0][1] = 1'b0;
      chk("rr ack count", seq.size() >= 4, 1'b1);
      if (seq.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk($sformatf("rr grant %0d", i), seq[i], i % 2);
         for (int i = 1; i < 4; i++) chk($sformatf("rr spacing %0d", i), when[i] - when[i-1], 3);
      end
      for (int k = 0; k < 4; k++) advance();

      // Fixed priority: r0 wins until it drops
      set_cmd(1, 0, 1'b1, 3'd0, 32'h0F0F_0F0F);
      set_cmd(1, 1, 1'b1, 3'd4, 32'hF000_0000);
      n0 = 0;
      n1 = 0;
      early_r1 = 1'b0;
      for (int k = 0; k < 24 && n1 == 0; k++) begin
         advance();
         if (ack[1][1] === 1'b1) begin
            if (n0 < 3) early_r1 = 1'b1;
            n1++;
            req[1][1] = 1'b0;
         end
         if (ack[1][0] === 1'b1) begin
            n0++;
            if (n0 == 3) req[1][0] = 1'b0;
         end
      end
      chk("fp r0 grants", n0, 3);
      chk("fp r1 granted after r0", n1, 1);
      chk("fp r1 not early", early_r1, 1'b0);
      for (int k = 0; k < 4; k++) advance();

      // r0 drops req while its write is on the bus
      do_txn(0, 0, 1'b1, 3'd0, 32'h5555_AAAA, 1'b1);
      chk("pio after early drop", pio[0], 32'h5555_AAAA);

      // Reset during ACCESS
      advance();
      advance();
      set_cmd(0, 1, 1'b0, 3'd0, 32'h0);
      set_cmd(1, 0, 1'b1, 3'd0, 32'hDEAD_BEEF);
      advance();
      chk("cs before reset", m_cs[0], 1'b1);
      reset_n = 1'b0;
      #1;
      model_reset();
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 2; r++) req[d][r] = 1'b0;
      check_all();
      advance();
      advance();
      reset_n = 1'b1;
      do_txn(1, 0, 1'b1, 3'd0, 32'hA5A5_5A5A, 1'b0);
      do_txn(0, 1, 1'b0, 3'd0, 32'h0, 1'b0);
      chk("read after reset", rd[0][1], 32'h5555_AAAA);

      // Randomized traffic on both instances
      for (int k = 0; k < 1500; k++) begin
         rand_stim();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
